mul4_vector_sequencer: RTL
==========================

MUL4_VECTOR_SEQUENCER -- requirements
Module: mul4_vector_sequencer

Interface
REQ-001 SHALL have parameter W, default 16, meaning operand/register width.
REQ-002 SHALL have parameter DEPTH, default 64, meaning program memory entries; AW = clog2(DEPTH).
REQ-003 SHALL have one clock and a synchronous active-high reset: clk input 1 (all state on rising edge), then rst input 1 (synchronous, active-high).
REQ-004 SHALL have ports: prog_we input 1 (program write strobe); prog_addr input AW (write address); prog_data input 8 (instruction word).
REQ-005 SHALL have ports: prog_len input AW+1 (instruction count, sampled at accept); in_valid input 1; in_ready output 1.
REQ-006 SHALL have ports: a1, a0, b1, b0 input W each (operands); out_valid output 1; out_ready input 1; y3, y2, y1, y0 output W each; busy output 1.

Function
REQ-007 SHALL hold working registers r0..r3 (W bits each), pc (AW bits) and len (AW+1 bits).
REQ-008 SHALL encode instructions as: [7:6] op (00 XOR, 01 OR, 10 AND, 11 NOT); [5:4] dst; [3] src_sel (0 = register, 1 = input); [2:1] src index; [0] ignored.
REQ-009 SHALL map input src index 0..3 to a0, a1, b0, b1.
REQ-010 SHALL execute XOR/OR/AND as r[dst] = r[dst] op src, bitwise over W bits.
REQ-011 SHALL execute NOT as a logical negation: r[dst] = 1 when src == 0, else 0 (zero-extended to W).
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; reset state is IDLE.
REQ-013 SHALL drive in_ready = (state == IDLE), out_valid = (state == DONE) and busy = (state != IDLE).
REQ-014 On an IDLE edge with in_valid=1, SHALL load r0=a0, r1=a1, r2=b0, r3=b1 and pc=0, latch operands for input-sourced instructions, and set len = min(prog_len, DEPTH).
REQ-015 On that same accept edge, SHALL go to DONE when the clamped len is 0, else to RUN.
REQ-016 In RUN, SHALL execute mem[pc] once per edge and increment pc.
REQ-017 In RUN, SHALL go to DONE on the edge that executes pc == len-1.
REQ-018 SHALL assert out_valid exactly len edges after the accept edge (len=0: immediately after the accept edge).
REQ-019 SHALL drive y3=r3, y2=r2, y1=r1, y0=r0, held stable while in DONE.
REQ-020 SHALL stay in DONE while out_ready=0.
REQ-021 On a DONE edge with out_ready=1, SHALL go to IDLE; the next accept is possible one cycle later (one bubble between jobs).
REQ-022 On an edge with prog_we=1 and state == IDLE, SHALL write mem[prog_addr] = prog_data.
REQ-023 SHALL silently ignore prog_we while busy=1.
REQ-024 SHALL ignore in_valid outside IDLE; operand changes during RUN SHALL NOT affect the result (latched copies are used).
REQ-025 SHALL give reads-after-write in the same IDLE cycle no special handling; the new contents take effect from the next job.

Reset
REQ-026 On an rst=1 edge, SHALL set state=IDLE, r0..r3=0, pc=0 and len=0, giving out_valid=0, busy=0, in_ready=1 and y3..y0=0.
REQ-027 SHALL NOT reset program memory; its contents after power-up are undefined until written.
REQ-028 SHALL give rst priority over all other inputs, including mid-RUN and while in DONE.

Verification
REQ-029 len=0 pass-through: prog_len=0, a0=0x1234, a1=0x00FF, b0=0x0F0F, b1=0xAAAA -> out_valid the cycle after accept; y0=0x1234, y1=0x00FF, y2=0x0F0F, y3=0xAAAA.
REQ-030 Two-instruction program: mem[0]=0x32 (r3^=r1), mem[1]=0xC8 (r0=!a0), len=2, a0=0x0000, a1=0x00FF, b0=0x1111, b1=0xAAAA -> out_valid 2 edges after accept; y0=0x0001, y1=0x00FF, y2=0x1111, y3=0xAA55.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> y stable, in_ready=0, no accept; out_ready=1 -> IDLE next edge, accept on the following edge.
REQ-032 Write-while-busy: prog_we to addr 0 with 0x00 during RUN of the REQ-030 program -> identical result on rerun; mem[0] unchanged.
REQ-033 Reset mid-operation: len=10, assert rst at the 3rd RUN edge -> next cycle out_valid=0, busy=0, in_ready=1, y3..y0=0; new job then runs correctly.
REQ-034 Clamp: prog_len=DEPTH+1 (e.g. 65) -> exactly 64 instructions executed; out_valid after 64 edges.

Source files
------------

// File: rtl/mul4_vector_sequencer.sv
// Four-register bitwise vector sequencer: it loads operands, runs a stored program of
// XOR/OR/AND/NOT instructions over r0..r3, then presents the registers with a valid/ready handshake.
module mul4_vector_sequencer #(
   parameter int W = 16,
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [7:0]    prog_data,
   input  logic [AW:0]   prog_len,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  a1,
   input  logic [W-1:0]  a0,
   input  logic [W-1:0]  b1,
   input  logic [W-1:0]  b0,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  y3,
   output logic [W-1:0]  y2,
   output logic [W-1:0]  y1,
   output logic [W-1:0]  y0,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t        state;
   state_t        state_next;
   logic [W-1:0]  r    [4];
   logic [W-1:0]  opnd [4];
   logic [7:0]    mem  [DEPTH];
   logic [AW-1:0] pc;
   logic [AW:0]   len;
   logic [AW:0]   len_clamped;
   logic [7:1]    instr;
   logic [W-1:0]  src_val;
   logic          accept;
   logic          last;

   function automatic logic [W-1:0] alu(input logic [1:0] op, input logic [W-1:0] d,
                                        input logic [W-1:0] s);
      logic [W-1:0] res;
      case (op)
         2'b00:   res = d ^ s;
         2'b01:   res = d | s;
         2'b10:   res = d & s;
         default: res = (s == {W{1'b0}}) ? {{(W-1){1'b0}}, 1'b1} : {W{1'b0}};
      endcase
      return res;
   endfunction

   assign accept      = (state == IDLE) && in_valid;
   assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
   assign instr       = mem[pc][7:1];
   assign last        = ({1'b0, pc} == (len - {{AW{1'b0}}, 1'b1}));
   assign src_val     = instr[3] ? opnd[instr[2:1]] : r[instr[2:1]];

   assign y0 = r[0];
   assign y1 = r[1];
   assign y2 = r[2];
   assign y3 = r[3];

   // Next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = (len_clamped == {(AW+1){1'b0}}) ? DONE : RUN;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            if (last) begin
               state_next = DONE;
            end else begin
               state_next = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end else begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register; handshake flags are registered from the next state so they match it exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         in_ready  <= (state_next == IDLE);
         out_valid <= (state_next == DONE);
         busy      <= (state_next != IDLE);
      end
   end

   // Working registers, operand latches, program counter and job length.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            r[i]    <= {W{1'b0}};
            opnd[i] <= {W{1'b0}};
         end
         pc  <= {AW{1'b0}};
         len <= {(AW+1){1'b0}};
      end else if (accept) begin
         r[0]    <= a0;
         r[1]    <= a1;
         r[2]    <= b0;
         r[3]    <= b1;
         opnd[0] <= a0;
         opnd[1] <= a1;
         opnd[2] <= b0;
         opnd[3] <= b1;
         pc      <= {AW{1'b0}};
         len     <= len_clamped;
      end else if (state == RUN) begin
         r[instr[5:4]] <= alu(instr[7:6], r[instr[5:4]], src_val);
         pc            <= pc + {{(AW-1){1'b0}}, 1'b1};
      end
   end

   // Program memory has no reset; writes are only honoured while idle.
   always_ff @(posedge clk) begin
      if (!rst && prog_we && (state == IDLE)) begin
         mem[prog_addr] <= prog_data;
      end
   end

endmodule
